div_unit: RTL and testbench

Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage. It produces the `stall_divE` request that freezes fetch, decode and execute while a division is in flight. It also delivers the 64-bit {remainder, quotient} pair that the mem-stage HI/LO write path consumes. It accepts a one-cycle annul so that an exception raised in mem can kill an in-flight division.

---
 rtl/div_unit.sv | 104 ++++++++++
 tb/tb_div_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with pipeline stall and annul.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one cycle with {a, all-ones}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_div_o,
  output logic               busy_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t stateQ, stateNext;

  logic [WIDTH-1:0]   absA, absB, absBQ, rem, quo, remNext, quoNext, remFix, quoFix;
  logic [WIDTH:0]     diff;
  logic [CW-1:0]      cnt;
  logic               signQ, signR, lastIter, zeroFast, readyInt;
  logic [2*WIDTH-1:0] resultQ;

  assign absA = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign absB = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

`ifdef DIV_ZERO_FAST_EN
  assign zeroFast = (b_i == '0);
`else
  assign zeroFast = 1'b0;
`endif

  // One restoring step: the bit shifted out of quo enters the remainder.
  assign diff     = {rem, quo[WIDTH-1]} - {1'b0, absBQ};
  assign remNext  = diff[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : diff[WIDTH-1:0];
  assign quoNext  = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign quoFix   = signQ ? -quoNext : quoNext;
  assign remFix   = signR ? -remNext : remNext;
  assign lastIter = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stateQ <= IDLE;
    else         stateQ <= stateNext;
  end

  always_comb begin
    stateNext = stateQ;
    if (annul_i) stateNext = IDLE;
    else begin
      case (stateQ)
        IDLE:    if (start_i) stateNext = zeroFast ? DONE : BUSY;
        BUSY:    if (lastIter) stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      absBQ   <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      signQ   <= 1'b0;
      signR   <= 1'b0;
      resultQ <= '0;
    end else if (!annul_i) begin
      case (stateQ)
        IDLE: if (start_i) begin
          if (zeroFast) begin
            resultQ <= {a_i, {WIDTH{1'b1}}};
          end else begin
            absBQ <= absB;
            rem   <= '0;
            quo   <= absA;
            cnt   <= '0;
            signQ <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            signR <= signed_i & a_i[WIDTH-1];
          end
        end
        BUSY: begin
          rem <= remNext;
          quo <= quoNext;
          cnt <= cnt + CW'(1);
          if (lastIter) resultQ <= {remFix, quoFix};
        end
        default: ;
      endcase
    end
  end

  // An annul in DONE suppresses the handoff so the killed result never commits.
  assign readyInt    = (stateQ == DONE) && !annul_i;
  assign ready_o     = readyInt;
  assign busy_o      = (stateQ == BUSY);
  assign stall_div_o = start_i & ~readyInt & ~annul_i;
  assign result_o    = resultQ;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a cycle-level arithmetic model checked every cycle,
// plus hand-computed literal results for the key vectors.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start_i = 1'b0, signed_i = 1'b0, annul_i = 1'b0;
  logic [W-1:0]  a_i = '0, b_i = '0;
  logic [2*W-1:0] result_o;
  logic          ready_o, stall_div_o, busy_o;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit go = 0, active = 0;
  int startCyc = 0, doneCyc = 0;
  logic [63:0] expRes = '0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .annul_i(annul_i), .a_i(a_i), .b_i(b_i), .result_o(result_o),
    .ready_o(ready_o), .stall_div_o(stall_div_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Architectural quotient/remainder (truncating division), plus the zero-divisor rules.
  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) begin
`ifdef DIV_ZERO_FAST_EN
      return {a, ONES};
`else
      q = longint'(ONES);
      r = (sg && a[31]) ? -longint'($signed(a)) : longint'(a);
      if (sg && (a[31] ^ b[31])) q = -q;
      if (sg && a[31]) r = -r;
      return {r[31:0], q[31:0]};
`endif
    end
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 0) return 1;
`endif
    return W + 1;
  endfunction

  // Per-cycle compare against the model's timeline.
  always @(negedge clk) begin
    if (go && resetn) begin
      bit expReady, expBusy, expStall;
      expReady = active && (cyc == doneCyc) && !annul_i;
      expBusy  = active && (cyc > startCyc) && (cyc < doneCyc);
      expStall = start_i && !annul_i && !expReady;
      chk("ready", 64'(ready_o), 64'(expReady));
      chk("busy", 64'(busy_o), 64'(expBusy));
      chk("stall", 64'(stall_div_o), 64'(expStall));
      if (expReady) chk("result", result_o, expRes);
    end
  end

  task automatic launch(input bit sg, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = sg; a_i = a; b_i = b;
    startCyc = cyc;
    doneCyc = cyc + latency(b);
    expRes = model(sg, a, b);
    active = 1;
  endtask

  task automatic waitDone(input logic [63:0] lit, input bit useLit);
    do @(negedge clk); while (cyc < doneCyc);
    if (useLit) begin
      chk("litReady", 64'(ready_o), 64'd1);
      chk("litResult", result_o, lit);
    end
  endtask

  task automatic runDiv(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit, input bit useLit);
    launch(sg, a, b);
    waitDone(lit, useLit);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0; active = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rstResult", result_o, 64'd0);
    chk("rstReady", 64'(ready_o), 64'd0);
    chk("rstBusy", 64'(busy_o), 64'd0);
    resetn = 1'b1;
    go = 1;

    // Back-to-back chain: each start lands in the IDLE cycle right after DONE.
    runDiv(0, 32'd7, 32'd2, {32'h1, 32'h3}, 1);
    runDiv(1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
    runDiv(1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 1);
    runDiv(1, 32'h8000_0000, ONES, {32'h0, 32'h8000_0000}, 1);
    runDiv(0, 32'h8000_0000, ONES, {32'h8000_0000, 32'h0}, 1);
    runDiv(0, 32'd5, 32'd0, {32'h5, ONES}, 1);
    runDiv(1, 32'hFFFF_FFFB, 32'd0, 64'd0, 0);
    runDiv(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h3}, 1);
    runDiv(0, ONES, 32'd1, 64'd0, 0);
    runDiv(0, 32'd1000, 32'd1001, {32'd1000, 32'd0}, 1);
    idle();

    // Annul mid-division, then a fresh divide two cycles later.
    launch(0, 32'd100, 32'd3);
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    idle();
    @(negedge clk) chk("annulIdle", 64'(busy_o), 64'd0);
    runDiv(0, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
    chk("annulRestartCycle", 64'(cyc - startCyc), 64'(latency(32'd7)));
    idle();

    // Annul coincident with DONE must hide ready.
    launch(0, 32'd50, 32'd5);
    repeat (W + 1) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk) chk("annulDone", 64'(ready_o), 64'd0);
    idle();

    // Asynchronous reset in the middle of a division.
    launch(0, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #1 resetn = 1'b0; start_i = 1'b0; active = 0;
    #1;
    chk("midRstResult", result_o, 64'd0);
    chk("midRstReady", 64'(ready_o), 64'd0);
    chk("midRstBusy", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    runDiv(0, 32'd9, 32'd3, {32'd0, 32'd3}, 1);
    idle();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
